alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage wrapped around alu32: accepts operand/opcode beats on a valid/ready
//  handshake, computes them through one alu32 instance, and buffers the result and
//  flags in a DEPTH-entry first-word-fall-through result queue for the writeback stage.
//  Decouples decode from writeback stalls; one op accepted per clock when not full.
// PARAMETERS
//  DEPTH   4  result queue entries; power of 2, >= 2
//  TAG_W   5  width of the pass-through tag (destination register number)
// PORTS
//  clock         in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  in_valid      in   1       upstream beat valid
//  in_ready      out  1       stage can accept a beat this cycle
//  in_a          in   32      ALU operand A
//  in_b          in   32      ALU operand B
//  in_ctrl       in   3       ALU control code (ADD=2 SUB=3 AND=4 OR=5 NOR=6 XOR=7)
//  in_tag        in   TAG_W   tag carried unchanged with the result
//  out_valid     out  1       queue head holds a result
//  out_ready     in   1       downstream consumes head this cycle
//  out_result    out  32      head result
//  out_zero      out  1       head zero flag
//  out_negative  out  1       head negative flag
//  out_overflow  out  1       head overflow flag (ADD/SUB only)
//  out_tag       out  TAG_W   head tag
//  count         out  log2(DEPTH)+1  occupied entries
//  trap          out  1       sticky overflow trap (OVF_TRAP_EN only, else 0)
//  trap_clear    in   1       clears trap (OVF_TRAP_EN only, else ignored)
// BEHAVIOUR
//  - Reset (async, active-high): rd/wr pointers and count = 0; all entry storage = 0;
//    out_valid=0, out_result=0, out_zero/out_negative/out_overflow=0, out_tag=0, trap=0,
//    in_ready=1 once reset deasserts. Reset mid-operation discards all queued results.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH) & ~trap. No pass-through when full: a pop in the same
//    cycle does not enable a push (in_ready is registered-state only, no comb path
//    from out_ready).
//  - alu32 is driven combinationally by in_a/in_b/in_ctrl; on push its out, zero,
//    negative, overflow and in_tag are written into entry wr_ptr at the clock edge.
//  - Latency: beat accepted at edge N -> visible at head (if queue was empty) in the
//    cycle after edge N; out_* are driven directly from entry rd_ptr (FWFT, no comb
//    path from in_* to out_*).
//  - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0; count is one bit wider.
//  - push & pop same cycle: both pointers advance, count unchanged.
//  - pop when empty / push when full: impossible by handshake; state unchanged if
//    forced.
//  - in_ctrl 0, 1 (undefined codes): result 0, zero=1, negative=0, overflow=0;
//    enqueued normally.
//  - out_* hold stable while out_valid=1 & out_ready=0.
// CONFIGURATION
//  OVF_TRAP_EN defined: a push whose alu32 overflow=1 sets trap at that edge; the
//    overflowing result is still enqueued (out_overflow=1). While trap=1 in_ready=0;
//    the queue keeps draining. trap_clear=1 clears trap next edge; set and clear in
//    the same cycle -> set wins.
//  OVF_TRAP_EN undefined: trap tied 0, trap_clear ignored, overflow only reported
//    in out_overflow.
// TESTING
//  1. reset mid-stream with 3 queued -> count=0, out_valid=0, all out_* = 0,
//     in_ready=1 after release.
//  2. push ADD 5+7, tag 3, out_ready=1 -> next cycle out_valid=1, result=12,
//     zero=0, tag=3; popped, count back to 0.
//  3. out_ready=0, push 4 ops (SUB 1-1, NOR 0|0, XOR, AND) -> in_ready=0 at count=4;
//     drain in order: SUB result 0 zero=1, NOR 0xFFFFFFFF negative=1, ...;
//     pointers wrap correctly.
//  4. steady push+pop each cycle for 20 beats -> count constant, results in order,
//     no bubbles.
//  5. ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, negative=1; with OVF_TRAP_EN
//     trap=1 and in_ready=0 until trap_clear, then resumes; without it, in_ready
//     stays 1.
//  6. in_ctrl=1 with a=b=0xFFFFFFFF -> result 0, zero=1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage -- execute stage: one alu32 feeding a first-word-fall-through
// result queue that decouples decode from writeback stalls.
//
// Contents of this file:
//   alu32           32-bit combinational ALU. Opcodes: ADD=2 SUB=3 AND=4 OR=5
//                   NOR=6 XOR=7. All other codes give result 0.
//   alu_exec_stage  top level.
//
// alu_exec_stage ports:
//   clock, reset              rising-edge clock; asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (one op per clock when not full)
//   in_a, in_b, in_ctrl       ALU operands and control code
//   in_tag                    destination tag carried alongside the result
//   out_valid / out_ready     downstream handshake on the queue head
//   out_result, out_zero,
//   out_negative, out_overflow,
//   out_tag                   queue head contents, driven straight from storage
//   count                     number of occupied entries
//   trap, trap_clear          sticky overflow trap and its clear
//
// Parameters: DEPTH (power of 2, >= 2), TAG_W.
// Build option: define OVF_TRAP_EN to enable the sticky overflow trap. When it
// is undefined, trap is tied to 0 and trap_clear is ignored.
// ---------------------------------------------------------------------------

module alu32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  ctrl_i,
  output logic [31:0] out_o,
  output logic        zero_o,
  output logic        negative_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_NOR = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    out_o      = '0;
    overflow_o = 1'b0;
    case (ctrl_i)
      OP_ADD: begin
        out_o      = sum;
        // Signed overflow: operands agree in sign, result does not.
        overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      OP_SUB: begin
        out_o      = diff;
        overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      OP_AND:  out_o = a_i & b_i;
      OP_OR:   out_o = a_i | b_i;
      OP_NOR:  out_o = ~(a_i | b_i);
      OP_XOR:  out_o = a_i ^ b_i;
      default: out_o = '0;
    endcase
  end

  assign zero_o     = (out_o == '0);
  assign negative_o = out_o[31];

endmodule

module alu_exec_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [2:0]               in_ctrl,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_zero,
  output logic                     out_negative,
  output logic                     out_overflow,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     trap,
  input  logic                     trap_clear
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             alu_entry;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               trap_q, trap_d;
  logic               push, pop, full;

  alu32 u_alu (
    .a_i        (in_a),
    .b_i        (in_b),
    .ctrl_i     (in_ctrl),
    .out_o      (alu_entry.result),
    .zero_o     (alu_entry.zero),
    .negative_o (alu_entry.negative),
    .overflow_o (alu_entry.overflow)
  );
  assign alu_entry.tag = in_tag;

  // Ready depends only on registered state, so a pop cannot open a slot for a
  // push in the same cycle and there is no out_ready -> in_ready path.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = ~full & ~trap_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef OVF_TRAP_EN
  // A set on an overflowing push takes priority over a clear in the same cycle.
  always_comb begin
    trap_d = trap_q;
    if (trap_clear)                  trap_d = 1'b0;
    if (push && alu_entry.overflow)  trap_d = 1'b1;
  end
`else
  logic unused_trap_clear;
  assign unused_trap_clear = trap_clear;
  assign trap_d            = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      trap_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      trap_q   <= trap_d;
    end
  end

  // NOTE: the queue storage is reset deliberately -- the head is driven
  // straight from storage, so clearing it is what makes every out_* read 0
  // after reset. The queue is small, so resetting it is cheap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= alu_entry;
    end
  end

  // First-word-fall-through head: no combinational path from in_* to out_*.
  assign out_result   = mem_q[rd_ptr_q].result;
  assign out_zero     = mem_q[rd_ptr_q].zero;
  assign out_negative = mem_q[rd_ptr_q].negative;
  assign out_overflow = mem_q[rd_ptr_q].overflow;
  assign out_tag      = mem_q[rd_ptr_q].tag;
  assign count        = count_q;
  assign trap         = trap_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage -- directed and randomized bench for alu_exec_stage.
// A queue-based reference model computes ALU results with plain signed
// arithmetic and tracks occupancy and the trap bit. The bench compiles with or
// without OVF_TRAP_EN and follows whichever build is selected.
// ---------------------------------------------------------------------------

module tb_alu_exec_stage;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a, in_b;
  logic [2:0]        in_ctrl;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_zero, out_negative, out_overflow;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        count;
  logic              trap;
  logic              trap_clear;

  typedef struct packed {
    logic [31:0]      res;
    logic             z;
    logic             n;
    logic             o;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  bit   m_trap;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_exec_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ctrl      (in_ctrl),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .out_overflow (out_overflow),
    .out_tag      (out_tag),
    .count        (count),
    .trap         (trap),
    .trap_clear   (trap_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: signed overflow decided by range of the exact sum.
  function automatic exp_t model_alu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] c, input logic [TAG_W-1:0] t);
    exp_t   e;
    longint sa, sb, r;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.o   = 1'b0;
    e.res = 32'd0;
    case (c)
      3'd2: begin r = sa + sb; e.res = r[31:0]; e.o = (r > MAX_S) || (r < MIN_S); end
      3'd3: begin r = sa - sb; e.res = r[31:0]; e.o = (r > MAX_S) || (r < MIN_S); end
      3'd4: e.res = a & b;
      3'd5: e.res = a | b;
      3'd6: e.res = ~(a | b);
      3'd7: e.res = a ^ b;
      default: e.res = 32'd0;
    endcase
    e.z   = (e.res == 32'd0);
    e.n   = e.res[31];
    e.tag = t;
    return e;
  endfunction

  task automatic check_state();
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !m_trap));
    check("trap", 64'(trap), 64'(m_trap));
    if (q.size() != 0) begin
      check("head_result", 64'(out_result), 64'(q[0].res));
      check("head_zero", 64'(out_zero), 64'(q[0].z));
      check("head_negative", 64'(out_negative), 64'(q[0].n));
      check("head_overflow", 64'(out_overflow), 64'(q[0].o));
      check("head_tag", 64'(out_tag), 64'(q[0].tag));
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // compare 1 time unit later.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [TAG_W-1:0] t,
                      input bit rdy, input bit clr);
    exp_t e;
    bit   do_push, do_pop;
    @(negedge clock);
    in_valid   = v;
    in_a       = a;
    in_b       = b;
    in_ctrl    = c;
    in_tag     = t;
    out_ready  = rdy;
    trap_clear = clr;
    e       = model_alu(a, b, c, t);
    do_push = v && (q.size() < DEPTH) && !m_trap;
    do_pop  = rdy && (q.size() != 0);
    @(posedge clock);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
`ifdef OVF_TRAP_EN
    if (do_push && e.o) m_trap = 1'b1;
    else if (clr)       m_trap = 1'b0;
`endif
    #1;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_ctrl = 0; in_tag = 0;
    out_ready = 0; trap_clear = 0; m_trap = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_result", 64'(out_result), 0);
    check("rst_flags", 64'({out_zero, out_negative, out_overflow}), 0);
    check("rst_tag", 64'(out_tag), 0);
    check("rst_trap", 64'(trap), 0);
    reset = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 1);

    // Reset in the middle of a stream with three queued results.
    for (int i = 0; i < 3; i++) step(1, $urandom, $urandom, 3'd5, TAG_W'(i + 1), 0, 0);
    check("pre_reset_count", 64'(count), 3);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    q.delete();
    m_trap = 0;
    check("midrst_count", 64'(count), 0);
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_result", 64'(out_result), 0);
    check("midrst_flags", 64'({out_zero, out_negative, out_overflow}), 0);
    check("midrst_tag", 64'(out_tag), 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1 check("midrst_in_ready", 64'(in_ready), 1);

    // ADD 5+7, tag 3, downstream ready.
    step(1, 32'd5, 32'd7, 3'd2, 5'd3, 1, 0);
    check("add_valid", 64'(out_valid), 1);
    check("add_result", 64'(out_result), 12);
    check("add_zero", 64'(out_zero), 0);
    check("add_tag", 64'(out_tag), 3);
    step(0, 0, 0, 0, 0, 1, 0);
    check("add_popped_count", 64'(count), 0);

    // Fill to DEPTH with out_ready low, then drain in order.
    step(1, 32'd1, 32'd1, 3'd3, 5'd1, 0, 0);
    step(1, 32'd0, 32'd0, 3'd6, 5'd2, 0, 0);
    step(1, $urandom, $urandom, 3'd7, 5'd3, 0, 0);
    step(1, $urandom, $urandom, 3'd4, 5'd4, 0, 0);
    check("full_in_ready", 64'(in_ready), 0);
    check("full_count", 64'(count), 4);
    step(1, 32'd9, 32'd9, 3'd2, 5'd5, 0, 0);
    check("full_no_push", 64'(count), 4);
    check("sub_result", 64'(out_result), 0);
    check("sub_zero", 64'(out_zero), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("nor_result", 64'(out_result), 64'hFFFF_FFFF);
    check("nor_negative", 64'(out_negative), 1);
    drain();

    // Steady push+pop for 20 beats with one entry in flight.
    step(1, $urandom, $urandom, 3'd2, 5'd10, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom, $urandom, 3'($urandom_range(2, 7)), TAG_W'(i), 1, 0);
      check("steady_count", 64'(count), 1);
    end
    drain();

    // Signed overflow on ADD.
    step(1, 32'h7FFF_FFFF, 32'd1, 3'd2, 5'd9, 0, 0);
    check("ovf_result", 64'(out_result), 64'h8000_0000);
    check("ovf_flag", 64'(out_overflow), 1);
    check("ovf_negative", 64'(out_negative), 1);
`ifdef OVF_TRAP_EN
    check("ovf_trap", 64'(trap), 1);
    check("ovf_in_ready", 64'(in_ready), 0);
    step(1, 32'd1, 32'd2, 3'd2, 5'd8, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("trap_cleared", 64'(trap), 0);
    check("trap_resume", 64'(in_ready), 1);
    step(1, 32'h8000_0000, 32'd1, 3'd3, 5'd7, 0, 1);
    check("trap_set_wins", 64'(trap), 1);
    step(0, 0, 0, 0, 0, 0, 1);
`else
    check("no_trap_in_ready", 64'(in_ready), 1);
    check("no_trap", 64'(trap), 0);
`endif
    drain();

    // Undefined control code.
    step(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 5'd6, 0, 0);
    check("undef_result", 64'(out_result), 0);
    check("undef_zero", 64'(out_zero), 1);
    drain();

    // Randomized traffic including overflow-prone operands.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + $urandom_range(0, 31) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + $urandom_range(0, 31) : $urandom;
      step(bit'($urandom_range(0, 1)), a, b, 3'($urandom), TAG_W'($urandom),
           bit'($urandom_range(0, 2) != 0), $urandom_range(0, 7) == 0);
    end
    step(0, 0, 0, 0, 0, 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
